ccff_chain_loader: RTL and testbench

- Configuration-chain controller for a logic tile's ccff shift chain (LUT, mode and routing-mux SRAM bits in series from ccff_head to ccff_tail).
- Accepts configuration words from a host-side valid/ready stream and serializes them LSB-first onto ccff_head, producing the shift enable for the chain's clock-gate cell.
- Optional verify mode replays the bitstream a second time and checks that bits leaving ccff_tail match the first pass.
- Sits between the fabric's configuration port and the tile chain; runs on prog_clk.

---
 rtl/ccff_chain_loader.sv | 128 ++++++++++++
 tb/tb_ccff_chain_loader.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/ccff_chain_loader.sv
// rtl/ccff_chain_loader.sv - serializes host config words onto a tile ccff chain, with optional replay-and-compare verify
module ccff_chain_loader #(
  parameter int CHAIN_LEN = 20,
  parameter int WORD_W    = 8,
  localparam int CNT_W    = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset,
  input  logic              start,
  input  logic              verify_en,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  err_bit_idx
);

  localparam int WB_W = $clog2(WORD_W + 1);
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(CHAIN_LEN - 1);
  localparam logic [WB_W-1:0]  LAST_WB  = WB_W'(WORD_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, SHIFT, DONE} state_t;

  state_t            state_q, state_d;
  logic [WORD_W-1:0] shift_q, shift_d;
  logic [CNT_W-1:0]  bit_cnt_q, bit_cnt_d;
  logic [WB_W-1:0]   wb_cnt_q, wb_cnt_d;
  logic              pass_q, pass_d;
  logic              verify_q, verify_d;
  logic              error_q, error_d;
  logic [CNT_W-1:0]  err_idx_q, err_idx_d;

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    wb_cnt_d  = wb_cnt_q;
    pass_d    = pass_q;
    verify_d  = verify_q;
    error_d   = error_q;
    err_idx_d = err_idx_q;

    // Abort overrides everything, including a compare in the same cycle, so error is held as-is.
    if (abort && state_q != IDLE) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            state_d   = FETCH;
            verify_d  = verify_en;
            error_d   = 1'b0;
            err_idx_d = '0;
            bit_cnt_d = '0;
            pass_d    = 1'b0;
          end
        end
        FETCH: begin
          if (cfg_valid) begin
            shift_d  = cfg_data;
            wb_cnt_d = '0;
            state_d  = SHIFT;
          end
        end
        SHIFT: begin
          shift_d   = shift_q >> 1;
          bit_cnt_d = bit_cnt_q + CNT_W'(1);
          wb_cnt_d  = wb_cnt_q + WB_W'(1);
          // In pass 1 the tail is emitting the pass-0 copy of the bit now on the head.
          if (pass_q && !error_q && (ccff_tail != shift_q[0])) begin
            error_d   = 1'b1;
            err_idx_d = bit_cnt_q;
          end
          if (bit_cnt_q == LAST_BIT) begin
            if (verify_q && !pass_q) begin
              pass_d    = 1'b1;
              bit_cnt_d = '0;
              state_d   = FETCH;
            end else begin
              state_d = DONE;
            end
          end else if (wb_cnt_q == LAST_WB) begin
            state_d = FETCH;
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge prog_clk or negedge prog_reset) begin
    if (!prog_reset) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      wb_cnt_q  <= '0;
      pass_q    <= 1'b0;
      verify_q  <= 1'b0;
      error_q   <= 1'b0;
      err_idx_q <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      wb_cnt_q  <= wb_cnt_d;
      pass_q    <= pass_d;
      verify_q  <= verify_d;
      error_q   <= error_d;
      err_idx_q <= err_idx_d;
    end
  end

  assign cfg_ready     = (state_q == FETCH);
  assign ccff_shift_en = (state_q == SHIFT);
  assign ccff_head     = (state_q == SHIFT) & shift_q[0];
  assign busy          = (state_q != IDLE);
  assign done          = (state_q == DONE);
  assign error         = error_q;
  assign err_bit_idx   = err_idx_q;

endmodule

// File: tb/tb_ccff_chain_loader.sv
// tb/tb_ccff_chain_loader.sv - scoreboard bench for ccff_chain_loader with a behavioural chain model
module tb_ccff_chain_loader;

  localparam int CL    = 20;
  localparam int WW    = 8;
  localparam int CNT_W = $clog2(CL + 1);

  logic             prog_clk = 1'b0;
  logic             prog_reset;
  logic             start, verify_en, abort, cfg_valid;
  logic [WW-1:0]    cfg_data;
  logic             cfg_ready, ccff_head, ccff_tail, ccff_shift_en, busy, done, error;
  logic [CNT_W-1:0] err_bit_idx;

  ccff_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .prog_clk(prog_clk), .prog_reset(prog_reset), .start(start), .verify_en(verify_en),
    .abort(abort), .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_tail(ccff_tail), .ccff_shift_en(ccff_shift_en),
    .busy(busy), .done(done), .error(error), .err_bit_idx(err_bit_idx)
  );

  always #5 prog_clk = ~prog_clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Chain model: head enters bit 0, tail is the last flop; optional single-bit corruption.
  logic [CL-1:0] chain = '0;
  int            mshifts = 0;
  int            flip_at = -1;
  assign ccff_tail = chain[CL-1];

  always @(posedge prog_clk) begin
    logic [CL-1:0] nxt;
    if (ccff_shift_en) begin
      nxt = chain;
      if (mshifts == flip_at) nxt[6] = ~nxt[6];
      chain   <= {nxt[CL-2:0], ccff_head};
      mshifts <= mshifts + 1;
    end
  end

  bit exp_q[$];
  int shift_cnt = 0;
  int done_cnt  = 0;
  int hs_cnt    = 0;

  always @(negedge prog_clk) begin
    if (ccff_shift_en) begin
      shift_cnt++;
      if (exp_q.size() == 0) check("unexpected_shift", 32'd1, 32'd0);
      else check("head_bit", {31'd0, ccff_head}, {31'd0, exp_q.pop_front()});
    end
    if (done) done_cnt++;
  end

  logic [WW-1:0] words [3] = '{8'hA5, 8'h3C, 8'hF9};
  int            nbits [3] = '{8, 8, 4};

  task automatic send_word(input logic [WW-1:0] w, input int n);
    int k;
    cfg_data  = w;
    cfg_valid = 1'b1;
    for (k = 0; k < 200; k++) begin
      if (cfg_ready) break;
      @(negedge prog_clk);
    end
    check("fetch_timeout", {31'd0, cfg_ready}, 32'd1);
    for (int i = 0; i < n; i++) exp_q.push_back(w[i]);
    hs_cnt++;
    @(posedge prog_clk);
    @(negedge prog_clk);
  endtask

  task automatic start_pulse(input logic ve);
    start     = 1'b1;
    verify_en = ve;
    @(negedge prog_clk);
    start     = 1'b0;
    verify_en = 1'b0;
    check("start_busy", {31'd0, busy}, 32'd1);
    check("start_clr_err", {31'd0, error}, 32'd0);
    check("start_clr_idx", {{(32-CNT_W){1'b0}}, err_bit_idx}, 32'd0);
  endtask

  task automatic wait_done(output bit seen);
    seen = 0;
    for (int k = 0; k < 1000; k++) begin
      if (done) begin seen = 1; break; end
      @(negedge prog_clk);
    end
    check("done_timeout", {31'd0, seen}, 32'd1);
  endtask

  task automatic run_load(input logic ve, input bit gap, input logic exp_err, input int exp_idx);
    int  s0, d0, h0;
    bit  seen;
    s0 = shift_cnt; d0 = done_cnt; h0 = hs_cnt;
    start_pulse(ve);
    for (int p = 0; p < (ve ? 2 : 1); p++) begin
      for (int w = 0; w < 3; w++) begin
        send_word(words[w], nbits[w]);
        if (gap && p == 0 && w == 0) begin
          cfg_valid = 1'b0;
          for (int k = 0; k < 50 && !cfg_ready; k++) @(negedge prog_clk);
          for (int k = 0; k < 5; k++) begin
            check("gap_ready", {31'd0, cfg_ready}, 32'd1);
            check("gap_shift_en", {31'd0, ccff_shift_en}, 32'd0);
            @(negedge prog_clk);
          end
        end
      end
    end
    cfg_valid = 1'b0;
    wait_done(seen);
    check("done_error", {31'd0, error}, {31'd0, exp_err});
    if (exp_err) check("err_idx", {{(32-CNT_W){1'b0}}, err_bit_idx}, exp_idx);
    @(negedge prog_clk);
    check("after_done_idle", {31'd0, busy}, 32'd0);
    check("shift_count", shift_cnt - s0, (ve ? 2 : 1) * CL);
    check("done_count", done_cnt - d0, 1);
    check("handshakes", hs_cnt - h0, ve ? 6 : 3);
    check("queue_empty", exp_q.size(), 0);
  endtask

  initial begin
    int s0, d0;
    prog_reset = 1'b0;
    start = 0; verify_en = 0; abort = 0; cfg_valid = 0; cfg_data = '0;
    #23;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_shift_en", {31'd0, ccff_shift_en}, 32'd0);
    check("rst_head", {31'd0, ccff_head}, 32'd0);
    check("rst_ready", {31'd0, cfg_ready}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    @(negedge prog_clk);
    prog_reset = 1'b1;
    @(negedge prog_clk);

    run_load(1'b0, 1'b0, 1'b0, 0);
    run_load(1'b1, 1'b0, 1'b0, 0);

    flip_at = mshifts + CL;
    run_load(1'b1, 1'b0, 1'b1, 13);
    flip_at = -1;
    repeat (3) @(negedge prog_clk);
    check("error_sticky", {31'd0, error}, 32'd1);
    check("err_idx_sticky", {{(32-CNT_W){1'b0}}, err_bit_idx}, 32'd13);

    run_load(1'b0, 1'b1, 1'b0, 0);

    // Abort on the third shift cycle of the first word.
    s0 = shift_cnt; d0 = done_cnt;
    start_pulse(1'b0);
    send_word(8'h5A, 8);
    cfg_valid = 1'b0;
    repeat (2) @(negedge prog_clk);
    abort = 1'b1;
    @(negedge prog_clk);
    abort = 1'b0;
    check("abort_shift_en", {31'd0, ccff_shift_en}, 32'd0);
    check("abort_busy", {31'd0, busy}, 32'd0);
    exp_q.delete();
    repeat (5) @(negedge prog_clk);
    check("abort_no_done", done_cnt - d0, 0);
    check("abort_shifts", shift_cnt - s0, 3);
    check("abort_error_held", {31'd0, error}, 32'd0);

    run_load(1'b0, 1'b0, 1'b0, 0);

    // Start while busy is ignored, then async reset mid-shift.
    start_pulse(1'b0);
    send_word(8'hA5, 8);
    cfg_valid = 1'b0;
    start = 1'b1;
    @(negedge prog_clk);
    start = 1'b0;
    check("start_ignored_shift", {31'd0, ccff_shift_en}, 32'd1);
    #2 prog_reset = 1'b0;
    #1;
    check("arst_shift_en", {31'd0, ccff_shift_en}, 32'd0);
    check("arst_busy", {31'd0, busy}, 32'd0);
    check("arst_head", {31'd0, ccff_head}, 32'd0);
    check("arst_ready", {31'd0, cfg_ready}, 32'd0);
    check("arst_done", {31'd0, done}, 32'd0);
    exp_q.delete();
    @(negedge prog_clk);
    prog_reset = 1'b1;
    repeat (3) @(negedge prog_clk);
    check("post_rst_idle", {31'd0, busy}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
